seq_shift_add_mul: RTL and testbench
====================================

# seq_shift_add_mul

Sequential unsigned shift-and-add multiplier that consumes the `load`/`A`/`B` operand stimulus and produces the `busy`/`readyR` status pair plus a double-width product. It sits directly downstream of the operand/stimulus stage. It is the unit whose handshake that stage exercises: load pulse in, `busy` for the computation, `readyR` on completion. One multiplication runs at a time, one partial-product step per clock.

## Interface
- `width`, default 8, operand width in bits (≥2).
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: reset is asynchronous and active-high; clears all state immediately.
- `load` input 1: start request, sampled on rising edge.
- `A` input `width`: multiplicand, captured when a load is accepted.
- `B` input `width`: multiplier, captured when a load is accepted.
- `ack` input 1: result acknowledge; present only with `MUL_ACK_EN`.
- `busy` output 1: high while iterating.
- `readyR` output 1: result valid indication.
- `R` output `2*width`: product A×B, unsigned.

## Operation
- States: IDLE, RUN, DONE; reset → IDLE.
- Reset values: busy=0, readyR=0, R=0, counter=0, internal registers=0.
- IDLE, load=1: capture M←A, Q←B, acc←0, cnt←0; go to RUN.
- RUN, each edge: if Q[0]=1 then acc←acc+M, computed width+1 bits wide with carry kept; then shift {acc,Q} right one bit, carry into MSB; cnt←cnt+1.
  - When cnt reaches width−1, that step is the last; go to DONE.
- R is driven from the {acc,Q} register pair and is only meaningful when readyR=1. It is held stable from DONE until the next accepted load.
- load while RUN: ignored, no restart and no queuing.
- load in DONE: accepted as a new start, same as IDLE. It also acts as an implicit ack.
- Unsigned only; no overflow possible, since the product fits in 2*width bits.
- Reset mid-RUN: the operation is abandoned and all outputs return to reset values asynchronously.

## Timing
- Load accepted on edge k. busy=1 after edge k, through and including the cycle before edge k+width.
- busy is high for exactly width cycles.
- Edge k+width: busy→0, readyR→1, R final. busy and readyR are never high together.
- Latency from accepting edge to readyR: width cycles; 8 for the default.
- Without ack: readyR is a one-cycle pulse, after which DONE→IDLE.
- Back-to-back: load high in the DONE cycle starts the next operation on that edge, so busy rises as readyR falls.

## Configuration
- `MUL_ACK_EN` defined: `ack` port exists and DONE persists, with readyR=1, until an edge with ack=1 (→IDLE) or load=1 (→RUN, restart).
  - ack while not in DONE is ignored.
- `MUL_ACK_EN` undefined: no `ack` port, and readyR is the single-cycle pulse described above.

## Structure
- Package `mul_pkg`: state enum (IDLE, RUN, DONE) and default width constant. Counter width is $clog2(width) computed locally.
- One sub-module, `shift_add_dp`, holds M, acc, Q, the adder and the shifter. It is controlled by `init` and `step` strobes from the FSM in the top module.

## Test plan
- Reset held 40 ns then released, no load: busy=0, readyR=0, R=0 throughout.
- A=0xE9, B=0xC3, one-cycle load: busy high exactly 8 cycles, then readyR with R=0xB17B (45435).
- A=0xFF, B=0xFF: R=0xFE01. A=0x00, B=0xAB: R=0x0000. Both at 8-cycle latency.
- Load pulsed again mid-RUN with different operands: ignored, and the original product is reported.
- Reset asserted at the 4th RUN cycle: outputs clear immediately. A fresh load of 0x03×0x05 then gives R=0x000F.
- Load held high in the DONE cycle:
  - Without `MUL_ACK_EN`: the second operation starts with no idle gap.
  - With `MUL_ACK_EN`: readyR stays high 5 cycles until ack, then returns to IDLE.

Source files
------------

// File: rtl/seq_shift_add_mul_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_shift_add_mul_dp.sv
// Datapath: multiplicand M, accumulator acc and multiplier/low-product Q,
// with the (width+1)-bit adder and the combined right shift of {carry,acc,Q}.
module shift_add_dp
  import mul_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic               step,
  input  logic [width-1:0]   A,
  input  logic [width-1:0]   B,
  output logic [2*width-1:0] R
);

  logic [width-1:0] m;
  logic [width-1:0] acc;
  logic [width-1:0] q;
  logic [width:0]   sum;

  always_comb begin
    sum = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  end

  // The adder carry lands in acc's MSB; the bit shifted out of acc enters Q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m   <= '0;
      acc <= '0;
      q   <= '0;
    end else if (init) begin
      m   <= A;
      q   <= B;
      acc <= '0;
    end else if (step) begin
      acc <= sum[width:1];
      q   <= {sum[0], q[width-1:1]};
    end
  end

  assign R = {acc, q};

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// Optional MUL_ACK_EN: adds ack input; readyR then holds until ack or a new load.
module seq_shift_add_mul
  import mul_pkg::*;
#(
  parameter int unsigned width = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [width-1:0]   A,
  input  logic [width-1:0]   B,
`ifdef MUL_ACK_EN
  input  logic               ack,
`endif
  output logic               busy,
  output logic               readyR,
  output logic [2*width-1:0] R
);

  localparam int unsigned CNT_W = $clog2(width);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             init;
  logic             step;
  logic             last;

  assign last = (cnt == CNT_W'(width - 1));

  always_comb begin
    init = 1'b0;
    step = 1'b0;
    if (state != RUN) init = load;
    if (state == RUN) step = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      readyR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            cnt    <= '0;
            busy   <= 1'b0;
            readyR <= 1'b1;
          end
        end
        DONE: begin
          if (load) begin
            state  <= RUN;
            cnt    <= '0;
            busy   <= 1'b1;
            readyR <= 1'b0;
`ifdef MUL_ACK_EN
          end else if (ack) begin
            state  <= IDLE;
            readyR <= 1'b0;
          end
`else
          end else begin
            state  <= IDLE;
            readyR <= 1'b0;
          end
`endif
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          readyR <= 1'b0;
        end
      endcase
    end
  end

  shift_add_dp #(
    .width(width)
  ) u_dp (
    .clk  (clk),
    .reset(reset),
    .init (init),
    .step (step),
    .A    (A),
    .B    (B),
    .R    (R)
  );

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Directed self-checking bench for seq_shift_add_mul (width 8).
module tb_seq_shift_add_mul;

  localparam int WIDTH = 8;

  logic               clk;
  logic               reset;
  logic               load;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
`ifdef MUL_ACK_EN
  logic               ack;
`endif
  logic               busy;
  logic               readyR;
  logic [2*WIDTH-1:0] R;

  int compared;
  int mismatched;

  seq_shift_add_mul #(
    .width(WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .A     (A),
    .B     (B),
`ifdef MUL_ACK_EN
    .ack   (ack),
`endif
    .busy  (busy),
    .readyR(readyR),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      #5;
      compared++;
      if ({busy, readyR, R} !== {2'b00, 16'h0000}) begin
        mismatched++;
        $display("FAIL reset_hold t=%0t: busy=%b readyR=%b R=%h, want 0 0 0000", $time, busy, readyR, R);
      end
      #5;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({busy, readyR, R} !== {2'b00, 16'h0000}) begin
        mismatched++;
        $display("FAIL reset_idle cyc=%0d: busy=%b readyR=%b R=%h, want 0 0 0000", i, busy, readyR, R);
      end
    end
  endtask

  // Ends #1 after the edge where readyR should rise.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input int inject_at, input string name);
    @(negedge clk);
    A = a; B = b; load = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < WIDTH; i++) begin
      load = 1'b0;
      compared++;
      if ({busy, readyR} !== 2'b10) begin
        mismatched++;
        $display("FAIL %s_busy cyc=%0d: busy=%b readyR=%b, want 1 0", name, i, busy, readyR);
      end
      if (i == inject_at) begin
        A = ~a; B = 8'h11; load = 1'b1;
      end
      @(posedge clk); #1;
    end
    compared++;
    if ({busy, readyR, R} !== {2'b01, exp}) begin
      mismatched++;
      $display("FAIL %s_done: busy=%b readyR=%b R=%h, want 0 1 %h", name, busy, readyR, R, exp);
    end
  endtask

  task automatic finish_op(input logic [15:0] exp, input string name);
`ifdef MUL_ACK_EN
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({busy, readyR, R} !== {2'b01, exp}) begin
        mismatched++;
        $display("FAIL %s_hold cyc=%0d: busy=%b readyR=%b R=%h, want 0 1 %h", name, i, busy, readyR, R, exp);
      end
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
`else
    @(posedge clk); #1;
`endif
    compared++;
    if ({busy, readyR} !== 2'b00) begin
      mismatched++;
      $display("FAIL %s_idle: busy=%b readyR=%b, want 0 0", name, busy, readyR);
    end
  endtask

  task automatic test_multiply();
    run_op(8'hE9, 8'hC3, 16'hB17B, -1, "mul_e9c3");
    finish_op(16'hB17B, "mul_e9c3");
    run_op(8'hFF, 8'hFF, 16'hFE01, -1, "mul_ffff");
    finish_op(16'hFE01, "mul_ffff");
    run_op(8'h00, 8'hAB, 16'h0000, -1, "mul_00ab");
    finish_op(16'h0000, "mul_00ab");
  endtask

  task automatic test_load_during_run();
    run_op(8'h5A, 8'h3C, 16'h1518, 3, "mid_load");
    finish_op(16'h1518, "mid_load");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    A = 8'hE9; B = 8'hC3; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    compared++;
    if ({busy, readyR, R} !== {2'b00, 16'h0000}) begin
      mismatched++;
      $display("FAIL rst_mid: busy=%b readyR=%b R=%h, want 0 0 0000", busy, readyR, R);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(8'h03, 8'h05, 16'h000F, -1, "after_rst");
    finish_op(16'h000F, "after_rst");
  endtask

  task automatic test_back_to_back();
    run_op(8'h12, 8'h34, 16'h03A8, -1, "b2b_first");
    A = 8'hC8; B = 8'h0A; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    compared++;
    if ({busy, readyR} !== 2'b10) begin
      mismatched++;
      $display("FAIL b2b_restart: busy=%b readyR=%b, want 1 0", busy, readyR);
    end
    for (int i = 1; i < WIDTH; i++) begin
      @(posedge clk); #1;
      compared++;
      if ({busy, readyR} !== 2'b10) begin
        mismatched++;
        $display("FAIL b2b_busy cyc=%0d: busy=%b readyR=%b, want 1 0", i, busy, readyR);
      end
    end
    @(posedge clk); #1;
    compared++;
    if ({busy, readyR, R} !== {2'b01, 16'h07D0}) begin
      mismatched++;
      $display("FAIL b2b_second: busy=%b readyR=%b R=%h, want 0 1 07d0", busy, readyR, R);
    end
    finish_op(16'h07D0, "b2b_second");
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    load  = 1'b0;
    A     = '0;
    B     = '0;
`ifdef MUL_ACK_EN
    ack   = 1'b0;
`endif
    test_reset();
    test_multiply();
    test_load_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
